cordic_sched: RTL and testbench
===============================

CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 The block SHALL take parameter NREQ, default 4, as the number of requesters; IDW SHALL equal clog2(NREQ).
REQ-002 The block SHALL take parameter TIMEOUT, default 31, as the maximum number of cycles in RUN before the transaction is aborted.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- req  in  NREQ  per-requester request level
- req_angle  in  32*NREQ  signed angle, deg*1e7; slice k belongs to requester k
- resp_valid  out  NREQ  one-cycle one-hot completion pulse
- resp_id  out  IDW  index of the served requester
- resp_sine  out  32  signed result
- resp_cosine  out  32  signed result
- resp_err  out  1  timeout flag, qualified by resp_valid
- busy  out  1  high in every state except IDLE
- eng_s  out  1  CORDIC engine start level
- eng_angle  out  32  engine angle
- eng_done  in  1  engine done level
- eng_sine  in  32  engine sine result
- eng_cosine  in  32  engine cosine result

Function
REQ-005 The FSM SHALL have four states: IDLE, RUN, RESP and DRAIN.
REQ-006 In IDLE with req != 0, the block SHALL grant one requester by round-robin, latch its angle and id, and go to RUN on the next edge.
REQ-007 Round-robin priority SHALL start at last_grant+1 and wrap modulo NREQ; last_grant SHALL update on every grant.
REQ-008 In RUN, eng_s SHALL be 1 and eng_angle SHALL equal the latched angle, held stable for the whole of RUN.
REQ-009 In every state other than RUN, eng_s SHALL be 0; eng_angle SHALL keep its latched value.
REQ-010 In RUN, a timeout counter SHALL count from 0, starting on RUN entry.
REQ-011 In RUN with eng_done=1, the block SHALL capture eng_sine and eng_cosine, clear the error flag and go to RESP.
REQ-012 In RUN with eng_done=0 and counter==TIMEOUT, the block SHALL capture zeros, set the error flag and go to RESP.
REQ-013 If eng_done=1 and counter==TIMEOUT occur in the same cycle, eng_done SHALL take precedence.
REQ-014 In RESP, for exactly one cycle, resp_valid[id] SHALL be 1, and resp_id, resp_sine, resp_cosine and resp_err SHALL present the captured values; the next state SHALL be DRAIN.
REQ-015 resp_id, resp_sine, resp_cosine and resp_err SHALL hold their values until the next RESP.
REQ-016 DRAIN SHALL last at least one cycle and SHALL stay until eng_done=0, then go to IDLE.
REQ-017 req SHALL be sampled only in IDLE; a req still high on return to IDLE SHALL start a new transaction.
REQ-018 A requester SHALL hold req and its angle stable until its resp_valid pulse.
REQ-019 With an engine of 17-cycle done latency, the latency from grant edge to resp_valid SHALL be 19 cycles; the minimum issue interval SHALL be 21 cycles.
REQ-020 Deassertion of req[k] during service of k SHALL NOT abort the transaction; the response SHALL still be issued.

Reset
REQ-021 On rst=1, the state SHALL be IDLE and last_grant SHALL be NREQ-1, so requester 0 has first priority.
REQ-022 On rst=1, eng_s, resp_valid, resp_err and busy SHALL be 0, and resp_id, resp_sine, resp_cosine, eng_angle and the timeout counter SHALL be 0.
REQ-023 Reset mid-transaction SHALL drop eng_s in the same cycle, so the engine returns to idle, and SHALL emit no response.

Structure
REQ-024 The state encodings, the scale constant 1e7, the gain constant 6_073_000 and the nominal engine latency of 17 SHALL live in a shared cordic_defs package.
REQ-025 Round-robin selection SHALL be a combinational sub-module rr_arbiter(req, last_grant -> grant_onehot, grant_id).
REQ-026 The timeout counter SHALL reuse the existing counter module, with size = clog2(TIMEOUT+1).

Verification
REQ-027 Single request: req=4'b0001 with angle 300_000_000 against the real engine SHALL give resp_valid=4'b0001 19 cycles after grant, sine=5_000_000±2000, cosine=8_660_254±2000, err=0.
REQ-028 Contention: req=4'b1111 held SHALL serve ids in the order 0,1,2,3,0, with each resp_valid pulse exactly one cycle wide.
REQ-029 Wrap and fairness: after serving id 2, req=4'b0101 SHALL grant 0 before 2.
REQ-030 Timeout: an engine model with eng_done stuck at 0 SHALL give eng_s high for 32 cycles, then resp_err=1, sine=0, cosine=0, then IDLE.
REQ-031 Sticky done: eng_done held high 3 cycles after eng_s falls SHALL keep DRAIN for 3 cycles, with no new grant before eng_done=0.
REQ-032 Reset: asserting rst 5 cycles into RUN SHALL give eng_s=0 and busy=0 immediately with no resp_valid; after release, req=4'b1000 SHALL be served normally.

Source files
------------

// File: rtl/cordic_sched_pkg.sv
// cordic_defs: state encodings and CORDIC constants shared by the scheduler files.
package cordic_defs;
   typedef enum logic [1:0] {IDLE, RUN, RESP, DRAIN} state_t;
   localparam int SCALE   = 10_000_000;
   localparam int GAIN    = 6_073_000;
   localparam int ENG_LAT = 17;
endpackage

// File: rtl/cordic_sched_if.sv
// cordic_sched_if: requester and engine signals; slave is the scheduler, master the requester/engine side.
interface cordic_sched_if #(parameter int NREQ = 4, parameter int IDW = $clog2(NREQ));
   logic [NREQ-1:0]        req;
   logic [32*NREQ-1:0]     req_angle;
   logic [NREQ-1:0]        resp_valid;
   logic [IDW-1:0]         resp_id;
   logic signed [31:0]     resp_sine;
   logic signed [31:0]     resp_cosine;
   logic                   resp_err;
   logic                   busy;
   logic                   eng_s;
   logic signed [31:0]     eng_angle;
   logic                   eng_done;
   logic signed [31:0]     eng_sine;
   logic signed [31:0]     eng_cosine;
   modport master (output req, req_angle, eng_done, eng_sine, eng_cosine,
                   input resp_valid, resp_id, resp_sine, resp_cosine, resp_err, busy, eng_s, eng_angle);
   modport slave (input req, req_angle, eng_done, eng_sine, eng_cosine,
                  output resp_valid, resp_id, resp_sine, resp_cosine, resp_err, busy, eng_s, eng_angle);
endinterface

// File: rtl/cordic_sched_counter.sv
// counter: up-counter with async reset, synchronous clear and enable.
module counter #(parameter int SIZE = 5) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            en,
   output logic [SIZE-1:0] count
);
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (clr) count <= '0;
      else if (en) count <= count + 1'b1;
endmodule

// File: rtl/cordic_sched_rr.sv
// rr_arbiter: combinational round-robin pick starting at last_grant+1.
module rr_arbiter #(parameter int NREQ = 4, localparam int IDW = $clog2(NREQ)) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_grant,
   output logic [NREQ-1:0] grant_onehot,
   output logic [IDW-1:0]  grant_id
);
   logic [IDW-1:0] k;
   // scan from lowest priority upward so the highest-priority hit is written last
   always_comb begin
      k = '0;
      grant_id = '0;
      for (int i = NREQ; i >= 1; i--) begin
         k = IDW'((int'(last_grant) + i) % NREQ);
         if (req[k]) grant_id = k;
      end
   end
   assign grant_onehot = |req ? NREQ'(1) << grant_id : '0;
endmodule

// File: rtl/cordic_sched.sv
// cordic_sched: shares one CORDIC engine among NREQ requesters with round-robin grant and a run timeout.
module cordic_sched
   import cordic_defs::*;
#(
   parameter int NREQ = 4,
   parameter int TIMEOUT = 31,
   localparam int IDW = $clog2(NREQ),
   localparam int CW = $clog2(TIMEOUT + 1)
) (
   input logic clk,
   input logic rst,
   cordic_sched_if.slave bus
);
   state_t state, next;
   logic [NREQ-1:0] g_onehot;
   logic [IDW-1:0] g_id, last_grant, id, rid;
   logic [31:0] angle, sine, cosine;
   logic err, timed_out, done_now;
   logic [CW-1:0] cnt;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req(bus.req), .last_grant(last_grant), .grant_onehot(g_onehot), .grant_id(g_id)
   );
   counter #(.SIZE(CW)) u_cnt (
      .clk(clk), .rst(rst), .clr(state != RUN), .en(state == RUN), .count(cnt)
   );

   assign timed_out = cnt == CW'(TIMEOUT);
   assign done_now = state == RUN && (bus.eng_done || timed_out);

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         last_grant <= IDW'(NREQ - 1);
         id <= '0;
         rid <= '0;
         angle <= '0;
         sine <= '0;
         cosine <= '0;
         err <= 1'b0;
      end else begin
         state <= next;
         if (state == IDLE && |g_onehot) begin
            last_grant <= g_id;
            id <= g_id;
            angle <= bus.req_angle[32*int'(g_id) +: 32];
         end
         // engine result wins over a coincident timeout
         if (done_now) begin
            rid <= id;
            err <= !bus.eng_done;
            sine <= bus.eng_done ? bus.eng_sine : '0;
            cosine <= bus.eng_done ? bus.eng_cosine : '0;
         end
      end

   always_comb begin
      next = state;
      bus.eng_s = state == RUN;
      bus.busy = state != IDLE;
      bus.resp_valid = state == RESP ? NREQ'(1) << id : '0;
      case (state)
         IDLE:    next = |g_onehot ? RUN : IDLE;
         RUN:     next = done_now ? RESP : RUN;
         RESP:    next = DRAIN;
         DRAIN:   next = bus.eng_done ? DRAIN : IDLE;
         default: next = IDLE;
      endcase
   end

   assign bus.eng_angle = angle;
   assign bus.resp_id = rid;
   assign bus.resp_sine = sine;
   assign bus.resp_cosine = cosine;
   assign bus.resp_err = err;
endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: directed tests of the CORDIC scheduler against a 17-cycle engine model.
module tb_cordic_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int compared = 0;
   int mismatched = 0;
   int ecnt = 0, tail = 0, sticky = 1;
   bit stuck = 1'b0;

   cordic_sched_if #(.NREQ(4)) ifc();
   cordic_sched #(.NREQ(4), .TIMEOUT(31)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

   always #5 clk = ~clk;

   function automatic logic signed [31:0] msin(input logic signed [31:0] a);
      return a == 300_000_000 ? 32'sd5_000_000 : a >>> 4;
   endfunction
   function automatic logic signed [31:0] mcos(input logic signed [31:0] a);
      return a == 300_000_000 ? 32'sd8_660_254 : -a;
   endfunction

   // engine: done after 17 edges of eng_s, held for 'sticky' cycles after eng_s falls
   always @(posedge clk) begin
      if (ifc.eng_s) begin
         ecnt <= ecnt + 1;
         tail <= 0;
      end else if (tail + 1 < sticky) tail <= tail + 1;
      else begin
         ecnt <= 0;
         tail <= 0;
      end
   end
   assign ifc.eng_done = !stuck && ecnt >= 17;
   assign ifc.eng_sine = msin(ifc.eng_angle);
   assign ifc.eng_cosine = mcos(ifc.eng_angle);

   task automatic wait_resp(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ifc.resp_valid == '0 && n < 200);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && ifc.busy; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      ifc.req = '0;
      ifc.req_angle = '0;
      @(negedge clk);
      compared++;
      if ({ifc.busy, ifc.eng_s, ifc.resp_valid, ifc.resp_err, ifc.resp_id} !== '0) begin
         mismatched++;
         $display("FAIL reset_ctrl: got %b required 0", {ifc.busy, ifc.eng_s, ifc.resp_valid, ifc.resp_err, ifc.resp_id});
      end
      compared++;
      if ({ifc.resp_sine, ifc.resp_cosine} !== '0) begin
         mismatched++;
         $display("FAIL reset_data: got %h required 0", {ifc.resp_sine, ifc.resp_cosine});
      end
      compared++;
      if (ifc.eng_angle !== '0) begin
         mismatched++;
         $display("FAIL reset_angle: got %0d required 0", ifc.eng_angle);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      int n;
      ifc.req_angle[31:0] = 300_000_000;
      ifc.req = 4'b0001;
      @(negedge clk);
      compared++;
      if ({ifc.busy, ifc.eng_s} !== 2'b11 || ifc.eng_angle !== 300_000_000) begin
         mismatched++;
         $display("FAIL single_run: got busy/eng_s %b angle %0d required 11 300000000", {ifc.busy, ifc.eng_s}, ifc.eng_angle);
      end
      wait_resp(n);
      ifc.req = '0;
      compared++;
      if (n + 1 !== 19) begin
         mismatched++;
         $display("FAIL single_latency: got %0d required 19", n + 1);
      end
      compared++;
      if (ifc.resp_valid !== 4'b0001 || ifc.resp_id !== 2'd0 || ifc.resp_err !== 1'b0) begin
         mismatched++;
         $display("FAIL single_resp: got valid %b id %0d err %b required 0001 0 0", ifc.resp_valid, ifc.resp_id, ifc.resp_err);
      end
      compared++;
      if (ifc.resp_sine !== 5_000_000 || ifc.resp_cosine !== 8_660_254) begin
         mismatched++;
         $display("FAIL single_value: got %0d %0d required 5000000 8660254", ifc.resp_sine, ifc.resp_cosine);
      end
      @(negedge clk);
      compared++;
      if (ifc.resp_valid !== 4'b0000 || ifc.busy !== 1'b1) begin
         mismatched++;
         $display("FAIL single_drain: got valid %b busy %b required 0000 1", ifc.resp_valid, ifc.busy);
      end
      @(negedge clk);
      compared++;
      if (ifc.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL single_idle: got busy %b required 0", ifc.busy);
      end
   endtask

   task automatic test_contention();
      int n;
      logic [3:0] ev;
      logic [1:0] eid;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) ifc.req_angle[32*k +: 32] = (k + 1) * 16_000_000;
      ifc.req = 4'b1111;
      for (int r = 0; r < 5; r++) begin
         wait_resp(n);
         ev = 4'b0001 << (r % 4);
         eid = 2'(r % 4);
         if (r == 4) ifc.req = '0;
         compared++;
         if (n !== (r == 0 ? 19 : 20)) begin
            mismatched++;
            $display("FAIL contention_gap%0d: got %0d required %0d", r, n, r == 0 ? 19 : 20);
         end
         compared++;
         if (ifc.resp_valid !== ev || ifc.resp_id !== eid || ifc.resp_sine !== (r % 4 + 1) * 1_000_000) begin
            mismatched++;
            $display("FAIL contention_resp%0d: got valid %b id %0d sine %0d required %b %0d %0d",
                     r, ifc.resp_valid, ifc.resp_id, ifc.resp_sine, ev, eid, (r % 4 + 1) * 1_000_000);
         end
         @(negedge clk);
         compared++;
         if (ifc.resp_valid !== 4'b0000) begin
            mismatched++;
            $display("FAIL contention_width%0d: got %b required 0000", r, ifc.resp_valid);
         end
      end
      wait_idle();
   endtask

   task automatic test_wrap();
      int n;
      ifc.req = 4'b0100;
      wait_resp(n);
      ifc.req = '0;
      compared++;
      if (ifc.resp_id !== 2'd2) begin
         mismatched++;
         $display("FAIL wrap_first: got %0d required 2", ifc.resp_id);
      end
      wait_idle();
      ifc.req = 4'b0101;
      wait_resp(n);
      ifc.req = 4'b0100;
      compared++;
      if (ifc.resp_id !== 2'd0 || n !== 19) begin
         mismatched++;
         $display("FAIL wrap_zero: got id %0d lat %0d required 0 19", ifc.resp_id, n);
      end
      wait_resp(n);
      ifc.req = '0;
      compared++;
      if (ifc.resp_id !== 2'd2 || n !== 21) begin
         mismatched++;
         $display("FAIL wrap_two: got id %0d interval %0d required 2 21", ifc.resp_id, n);
      end
      wait_idle();
   endtask

   task automatic test_timeout();
      int c = 0;
      stuck = 1'b1;
      ifc.req = 4'b0010;
      @(negedge clk);
      while (ifc.eng_s && c < 100) begin
         c++;
         @(negedge clk);
      end
      ifc.req = '0;
      compared++;
      if (c !== 32) begin
         mismatched++;
         $display("FAIL timeout_run: got %0d cycles required 32", c);
      end
      compared++;
      if (ifc.resp_valid !== 4'b0010 || ifc.resp_err !== 1'b1 || ifc.resp_sine !== 0 || ifc.resp_cosine !== 0) begin
         mismatched++;
         $display("FAIL timeout_resp: got valid %b err %b sine %0d cos %0d required 0010 1 0 0",
                  ifc.resp_valid, ifc.resp_err, ifc.resp_sine, ifc.resp_cosine);
      end
      @(negedge clk);
      @(negedge clk);
      compared++;
      if (ifc.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL timeout_idle: got busy %b required 0", ifc.busy);
      end
      stuck = 1'b0;
   endtask

   task automatic test_sticky();
      int n, d = 0, g = 0;
      sticky = 3;
      ifc.req = 4'b1000;
      wait_resp(n);
      ifc.req = 4'b0001;
      compared++;
      if (ifc.resp_id !== 2'd3 || n !== 19) begin
         mismatched++;
         $display("FAIL sticky_resp: got id %0d lat %0d required 3 19", ifc.resp_id, n);
      end
      @(negedge clk);
      while (ifc.busy && d < 20) begin
         d++;
         if (ifc.eng_s) g++;
         @(negedge clk);
      end
      compared++;
      if (d !== 3 || g !== 0) begin
         mismatched++;
         $display("FAIL sticky_drain: got %0d drain %0d run cycles required 3 0", d, g);
      end
      compared++;
      if (ifc.resp_sine !== 4_000_000 || ifc.resp_id !== 2'd3) begin
         mismatched++;
         $display("FAIL sticky_hold: got sine %0d id %0d required 4000000 3", ifc.resp_sine, ifc.resp_id);
      end
      sticky = 1;
      wait_resp(n);
      ifc.req = '0;
      compared++;
      if (ifc.resp_id !== 2'd0 || n !== 19 || ifc.resp_sine !== 1_000_000) begin
         mismatched++;
         $display("FAIL sticky_next: got id %0d lat %0d sine %0d required 0 19 1000000", ifc.resp_id, n, ifc.resp_sine);
      end
      wait_idle();
   endtask

   task automatic test_reset_mid();
      int n, p = 0;
      ifc.req = 4'b1000;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      compared++;
      if ({ifc.eng_s, ifc.busy, ifc.resp_valid} !== '0) begin
         mismatched++;
         $display("FAIL midreset_now: got eng_s/busy/valid %b required 0", {ifc.eng_s, ifc.busy, ifc.resp_valid});
      end
      repeat (2) begin
         @(negedge clk);
         if (|ifc.resp_valid) p++;
      end
      compared++;
      if (p !== 0 || ifc.resp_sine !== 0 || ifc.resp_id !== 2'd0) begin
         mismatched++;
         $display("FAIL midreset_quiet: got pulses %0d sine %0d id %0d required 0 0 0", p, ifc.resp_sine, ifc.resp_id);
      end
      rst = 1'b0;
      wait_resp(n);
      ifc.req = '0;
      compared++;
      if (ifc.resp_valid !== 4'b1000 || n !== 19 || ifc.resp_sine !== 4_000_000 || ifc.resp_err !== 1'b0) begin
         mismatched++;
         $display("FAIL midreset_after: got valid %b lat %0d sine %0d err %b required 1000 19 4000000 0",
                  ifc.resp_valid, n, ifc.resp_sine, ifc.resp_err);
      end
      wait_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_wrap();
      test_timeout();
      test_sticky();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
